// File: rtl/encrypting_entity.sv
// ElGamal encryption stage: c1 = g^k mod p, c2 = m*h^k mod p using constant-time
// LSB-first square-and-multiply built from interleaved shift-add modular multipliers.
module encrypting_entity #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_key_p_tdata,
  input  logic [SIZE-1:0] input_key_g_tdata,
  input  logic [SIZE-1:0] input_key_h_tdata,
  input  logic            input_key_tvalid,
  output logic            input_key_tready,
  input  logic [SIZE-1:0] input_msg_tdata,
  input  logic [SIZE-1:0] input_nonce_tdata,
  input  logic            input_msg_tvalid,
  output logic            input_msg_tready,
  output logic [SIZE-1:0] output_c1_tdata,
  output logic [SIZE-1:0] output_c2_tdata,
  output logic            output_error,
  output logic            output_tvalid,
  input  logic            output_tready,
  output logic            key_loaded
);

  localparam int CW = $clog2(SIZE + 2);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] KEYED = 3'd1;
  localparam logic [2:0] EXP   = 3'd2;
  localparam logic [2:0] FINAL = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  logic [2:0]      state;
  logic [SIZE-1:0] key_p, key_g, key_h;
  logic            key_good;
  logic [SIZE-1:0] p_w, m_w, ks;
  logic [SIZE-1:0] acc1, acc2, b1, b2;
  logic [SIZE-1:0] sa1, sa2, sa3, sa4;
  logic [SIZE-1:0] r1, r2, r3, r4;
  logic [CW-1:0]   cnt, iter;
  logic            reject_q;

  logic            key_xfer, msg_xfer, out_xfer;
  logic            reject, new_key_good;
  logic [SIZE-1:0] step1, step2, step3, step4, b2_sel;
  logic [SIZE-1:0] acc1_upd, acc2_upd;

  // One shift-add step: r <- 2r mod p, then r <- (r + b) mod p when the multiplier bit is set.
  function automatic logic [SIZE-1:0] mod_step(input logic [SIZE-1:0] r,
                                               input logic [SIZE-1:0] b,
                                               input logic [SIZE-1:0] p,
                                               input logic            abit);
    logic [SIZE+1:0] t;
    logic [SIZE+1:0] pp;
    pp = {2'b00, p};
    t  = {1'b0, r, 1'b0};
    if (t >= pp) t = t - pp;
    if (abit) t = t + {2'b00, b};
    if (t >= pp) t = t - pp;
    return t[SIZE-1:0];
  endfunction

  assign key_xfer = input_key_tvalid && input_key_tready;
  assign msg_xfer = input_msg_tvalid && input_msg_tready;
  assign out_xfer = output_tvalid && output_tready;

  // The reject decision always uses the key held before this edge.
  assign reject = !key_good || (input_msg_tdata >= key_p) || (input_nonce_tdata == '0) ||
                  (input_nonce_tdata > key_p - SIZE'(2));
  assign new_key_good = (input_key_p_tdata >= SIZE'(3)) &&
                        (input_key_g_tdata < input_key_p_tdata) &&
                        (input_key_h_tdata < input_key_p_tdata);

  // In FINAL the second multiplier is reused for m * acc2.
  assign b2_sel   = (state == FINAL) ? acc2 : b2;
  assign step1    = mod_step(r1, b1,     p_w, sa1[SIZE-1]);
  assign step2    = mod_step(r2, b2_sel, p_w, sa2[SIZE-1]);
  assign step3    = mod_step(r3, b1,     p_w, sa3[SIZE-1]);
  assign step4    = mod_step(r4, b2,     p_w, sa4[SIZE-1]);
  assign acc1_upd = ks[0] ? r1 : acc1;
  assign acc2_upd = ks[0] ? r2 : acc2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      key_p            <= '0;
      key_g            <= '0;
      key_h            <= '0;
      key_good         <= 1'b0;
      key_loaded       <= 1'b0;
      p_w              <= '0;
      m_w              <= '0;
      ks               <= '0;
      acc1             <= '0;
      acc2             <= '0;
      b1               <= '0;
      b2               <= '0;
      sa1              <= '0;
      sa2              <= '0;
      sa3              <= '0;
      sa4              <= '0;
      r1               <= '0;
      r2               <= '0;
      r3               <= '0;
      r4               <= '0;
      cnt              <= '0;
      iter             <= '0;
      reject_q         <= 1'b0;
      input_key_tready <= 1'b0;
      input_msg_tready <= 1'b0;
      output_c1_tdata  <= '0;
      output_c2_tdata  <= '0;
      output_error     <= 1'b0;
      output_tvalid    <= 1'b0;
    end else begin
      case (state)
        IDLE, KEYED: begin
          input_key_tready <= 1'b1;
          input_msg_tready <= (state == KEYED) || key_xfer;
          if (key_xfer) begin
            key_p      <= input_key_p_tdata;
            key_g      <= input_key_g_tdata;
            key_h      <= input_key_h_tdata;
            key_good   <= new_key_good;
            key_loaded <= 1'b1;
            state      <= KEYED;
          end
          if (msg_xfer) begin
            p_w              <= key_p;
            m_w              <= input_msg_tdata;
            ks               <= input_nonce_tdata;
            reject_q         <= reject;
            acc1             <= SIZE'(1);
            acc2             <= SIZE'(1);
            b1               <= key_g;
            b2               <= key_h;
            sa1              <= SIZE'(1);
            sa2              <= SIZE'(1);
            sa3              <= key_g;
            sa4              <= key_h;
            r1               <= '0;
            r2               <= '0;
            r3               <= '0;
            r4               <= '0;
            cnt              <= '0;
            iter             <= '0;
            input_key_tready <= 1'b0;
            input_msg_tready <= 1'b0;
            state            <= EXP;
          end
        end

        EXP: begin
          if (reject_q) begin
            output_c1_tdata <= '0;
            output_c2_tdata <= '0;
            output_error    <= 1'b1;
            output_tvalid   <= 1'b1;
            state           <= OUT;
          end else if (cnt != CW'(SIZE)) begin
            r1  <= step1;
            r2  <= step2;
            r3  <= step3;
            r4  <= step4;
            sa1 <= sa1 << 1;
            sa2 <= sa2 << 1;
            sa3 <= sa3 << 1;
            sa4 <= sa4 << 1;
            cnt <= cnt + CW'(1);
          end else begin
            // Update cycle: products are always computed, only the selection depends on k.
            acc1 <= acc1_upd;
            acc2 <= acc2_upd;
            b1   <= r3;
            b2   <= r4;
            sa1  <= acc1_upd;
            sa2  <= acc2_upd;
            sa3  <= r3;
            sa4  <= r4;
            ks   <= ks >> 1;
            r1   <= '0;
            r2   <= '0;
            r3   <= '0;
            r4   <= '0;
            cnt  <= '0;
            if (iter == CW'(SIZE - 1)) state <= FINAL;
            else iter <= iter + CW'(1);
          end
        end

        FINAL: begin
          if (cnt == '0) begin
            r2  <= '0;
            sa2 <= m_w;
            cnt <= CW'(1);
          end else if (cnt != CW'(SIZE + 1)) begin
            r2  <= step2;
            sa2 <= sa2 << 1;
            cnt <= cnt + CW'(1);
          end else begin
            output_c1_tdata <= acc1;
            output_c2_tdata <= r2;
            output_error    <= 1'b0;
            output_tvalid   <= 1'b1;
            cnt             <= '0;
            state           <= OUT;
          end
        end

        OUT: begin
          if (out_xfer) begin
            output_tvalid    <= 1'b0;
            input_key_tready <= 1'b1;
            input_msg_tready <= 1'b1;
            state            <= KEYED;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encrypting_entity.sv
// Self-checking bench for encrypting_entity at SIZE=16: directed ElGamal cases plus
// randomized keys/messages checked against a plain-arithmetic modular exponentiation model.
module tb_encrypting_entity;

  localparam int SIZE = 16;
  localparam int LAT  = SIZE * (SIZE + 1) + SIZE + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] input_key_p_tdata, input_key_g_tdata, input_key_h_tdata;
  logic            input_key_tvalid, input_key_tready;
  logic [SIZE-1:0] input_msg_tdata, input_nonce_tdata;
  logic            input_msg_tvalid, input_msg_tready;
  logic [SIZE-1:0] output_c1_tdata, output_c2_tdata;
  logic            output_error, output_tvalid, output_tready, key_loaded;

  int tests  = 0;
  int failed = 0;

  longint mp, mg, mh;
  bit     mgood;

  encrypting_entity #(.SIZE(SIZE)) dut (
    .clk               (clk),
    .rst               (rst),
    .input_key_p_tdata (input_key_p_tdata),
    .input_key_g_tdata (input_key_g_tdata),
    .input_key_h_tdata (input_key_h_tdata),
    .input_key_tvalid  (input_key_tvalid),
    .input_key_tready  (input_key_tready),
    .input_msg_tdata   (input_msg_tdata),
    .input_nonce_tdata (input_nonce_tdata),
    .input_msg_tvalid  (input_msg_tvalid),
    .input_msg_tready  (input_msg_tready),
    .output_c1_tdata   (output_c1_tdata),
    .output_c2_tdata   (output_c2_tdata),
    .output_error      (output_error),
    .output_tvalid     (output_tvalid),
    .output_tready     (output_tready),
    .key_loaded        (key_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic longint pow_mod(longint b, longint e, longint p);
    longint r = 1;
    b = b % p;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % p;
      b = (b * b) % p;
      e = e / 2;
    end
    return r % p;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_key(input longint p, input longint g, input longint h);
    int w = 0;
    while (!input_key_tready && w < 1000) begin
      @(posedge clk); #1; w++;
    end
    check_output("key_tready_wait", input_key_tready, 1);
    input_key_p_tdata = p[SIZE-1:0];
    input_key_g_tdata = g[SIZE-1:0];
    input_key_h_tdata = h[SIZE-1:0];
    input_key_tvalid  = 1'b1;
    @(posedge clk); #1;
    input_key_tvalid  = 1'b0;
    mp = p; mg = g; mh = h;
    mgood = (p >= 3) && (g < p) && (h < p);
    check_output("key_loaded", key_loaded, 1);
  endtask

  // Sends one message (optionally with a key on the same edge) and checks the result.
  task automatic apply_stimulus(input longint m, input longint k, input bit with_key,
                                input longint kp, input longint kg, input longint kh,
                                input int hold);
    bit     e_err;
    longint e_c1, e_c2;
    int     w = 0;
    int     n = 0;
    logic [SIZE-1:0] h1, h2;
    e_err = !mgood || (m >= mp) || (k == 0) || (k > mp - 2);
    e_c1  = e_err ? 0 : pow_mod(mg, k, mp);
    e_c2  = e_err ? 0 : (m * pow_mod(mh, k, mp)) % mp;
    while (!input_msg_tready && w < 1000) begin
      @(posedge clk); #1; w++;
    end
    check_output("msg_tready_wait", input_msg_tready, 1);
    input_msg_tdata   = m[SIZE-1:0];
    input_nonce_tdata = k[SIZE-1:0];
    input_msg_tvalid  = 1'b1;
    if (with_key) begin
      input_key_p_tdata = kp[SIZE-1:0];
      input_key_g_tdata = kg[SIZE-1:0];
      input_key_h_tdata = kh[SIZE-1:0];
      input_key_tvalid  = 1'b1;
    end
    @(posedge clk); #1;
    input_msg_tvalid = 1'b0;
    input_key_tvalid = 1'b0;
    if (with_key) begin
      mp = kp; mg = kg; mh = kh;
      mgood = (kp >= 3) && (kg < kp) && (kh < kp);
    end
    while (!output_tvalid && n < LAT + 20) begin
      @(posedge clk); #1; n++;
    end
    check_output("latency", n, e_err ? 1 : LAT);
    check_output("error", output_error, e_err);
    check_output("c1", output_c1_tdata, e_c1);
    check_output("c2", output_c2_tdata, e_c2);
    h1 = output_c1_tdata;
    h2 = output_c2_tdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_output("hold_tvalid", output_tvalid, 1);
      check_output("hold_c1", output_c1_tdata, h1);
      check_output("hold_c2", output_c2_tdata, h2);
      check_output("hold_msg_tready", input_msg_tready, 0);
    end
    output_tready = 1'b1;
    @(posedge clk); #1;
    output_tready = 1'b0;
    check_output("tvalid_drop", output_tvalid, 0);
  endtask

  initial begin
    longint p, g, h, m, k;
    rst               = 1'b0;
    input_key_p_tdata = '0;
    input_key_g_tdata = '0;
    input_key_h_tdata = '0;
    input_key_tvalid  = 1'b0;
    input_msg_tdata   = '0;
    input_nonce_tdata = '0;
    input_msg_tvalid  = 1'b0;
    output_tready     = 1'b0;
    mp = 0; mg = 0; mh = 0; mgood = 0;

    #23;
    check_output("rst_tvalid", output_tvalid, 0);
    check_output("rst_key_loaded", key_loaded, 0);
    check_output("rst_key_tready", input_key_tready, 0);
    check_output("rst_msg_tready", input_msg_tready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("idle_key_tready", input_key_tready, 1);
    check_output("idle_msg_tready", input_msg_tready, 0);

    load_key(23, 5, 8);
    apply_stimulus(10, 3, 0, 0, 0, 0, 0);
    apply_stimulus(10, 1, 0, 0, 0, 0, 20);
    apply_stimulus(10, 22, 0, 0, 0, 0, 0);
    apply_stimulus(10, 0, 0, 0, 0, 0, 0);
    apply_stimulus(23, 3, 0, 0, 0, 0, 0);
    apply_stimulus(10, 21, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of an exponentiation.
    input_msg_tdata   = 16'd10;
    input_nonce_tdata = 16'd3;
    input_msg_tvalid  = 1'b1;
    @(posedge clk); #1;
    input_msg_tvalid = 1'b0;
    repeat (50) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("mid_rst_tvalid", output_tvalid, 0);
    check_output("mid_rst_error", output_error, 0);
    check_output("mid_rst_c1", output_c1_tdata, 0);
    check_output("mid_rst_c2", output_c2_tdata, 0);
    check_output("mid_rst_key_loaded", key_loaded, 0);
    check_output("mid_rst_msg_tready", input_msg_tready, 0);
    mp = 0; mg = 0; mh = 0; mgood = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("post_rst_key_tready", input_key_tready, 1);
    check_output("post_rst_msg_tready", input_msg_tready, 0);
    check_output("post_rst_key_loaded", key_loaded, 0);
    repeat (LAT) @(posedge clk);
    #1;
    check_output("post_rst_no_output", output_tvalid, 0);

    load_key(2, 5, 8);
    apply_stimulus(1, 1, 0, 0, 0, 0, 0);
    load_key(23, 23, 8);
    apply_stimulus(10, 3, 0, 0, 0, 0, 0);
    load_key(23, 5, 8);
    apply_stimulus(10, 3, 0, 0, 0, 0, 0);

    apply_stimulus(10, 3, 1, 29, 2, 7, 0);
    apply_stimulus(10, 5, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      p = $urandom_range(65535, 3);
      g = $urandom_range(p - 1, 0);
      h = $urandom_range(p - 1, 0);
      load_key(p, g, h);
      for (int j = 0; j < 3; j++) begin
        m = ($urandom_range(3, 0) == 0) ? $urandom_range(65535, p) : $urandom_range(p - 1, 0);
        case ($urandom_range(5, 0))
          0:       k = 0;
          1:       k = p - 1;
          2:       k = p - 2;
          default: k = (p > 3) ? $urandom_range(p - 2, 1) : 1;
        endcase
        apply_stimulus(m, k, 0, 0, 0, 0, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
